tlb_ctrl: RTL and testbench

//  Parametrised MIPS-style joint TLB: TLBNUM dual-page entries, NSPORT registered search ports,
//  and one read/write port with indexed or random replacement. It also runs a background flush

---
 rtl/tlb_ctrl_pkg.sv | 33 +++
 rtl/tlb_ctrl_match.sv | 35 +++
 rtl/tlb_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_tlb_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_ctrl_pkg.sv
// Shared types for the joint TLB: the packed entry layout, field widths and the flush FSM states.
package tlb_ctrl_pkg;

   localparam int VPN2_W = 19;
   localparam int ASID_W = 8;
   localparam int PFN_W  = 20;
   localparam int C_W    = 3;

   // Field order fixes the bit positions: vpn2[77:59] asid[58:51] g[50] pfn0[49:30] c0[29:27]
   // d0[26] v0[25] pfn1[24:5] c1[4:2] d1[1] v1[0].
   typedef struct packed {
      logic [VPN2_W-1:0] vpn2;
      logic [ASID_W-1:0] asid;
      logic              g;
      logic [PFN_W-1:0]  pfn0;
      logic [C_W-1:0]    c0;
      logic              d0;
      logic              v0;
      logic [PFN_W-1:0]  pfn1;
      logic [C_W-1:0]    c1;
      logic              d1;
      logic              v1;
   } tlb_entry_t;

   localparam int TLB_ENTRY_W = $bits(tlb_entry_t);

   typedef enum logic [1:0] {
      FL_IDLE = 2'd0,
      FL_WALK = 2'd1,
      FL_DONE = 2'd2
   } flush_state_e;

endpackage

// File: rtl/tlb_ctrl_match.sv
// One search port: per-entry compare, lowest-index priority encode and multi-hit detect.
module tlb_ctrl_match
   import tlb_ctrl_pkg::*;
#(
   parameter  int TLBNUM = 32,
   localparam int IDXW   = $clog2(TLBNUM)
) (
   input  logic [TLBNUM-1:0]             e,
   input  logic [TLBNUM-1:0][VPN2_W-1:0] vpn2,
   input  logic [TLBNUM-1:0][ASID_W-1:0] asid,
   input  logic [TLBNUM-1:0]             g,
   input  logic [VPN2_W-1:0]             q_vpn2,
   input  logic [ASID_W-1:0]             q_asid,
   output logic                          found,
   output logic                          multi,
   output logic [IDXW-1:0]               index
);

   logic [TLBNUM-1:0] hit;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
      hit   = '0;
      index = '0;
      for (int i = 0; i < TLBNUM; i++)
         hit[i] = e[i] && (vpn2[i] == q_vpn2) && (g[i] || (asid[i] == q_asid));
      for (int i = TLBNUM - 1; i >= 0; i--)
         if (hit[i]) index = IDXW'(i);
   end

   assign found = |hit;
   // Clearing the lowest set bit leaves something only if a second entry hit.
   assign multi = |(hit & (hit - TLBNUM'(1)));

endmodule

// File: rtl/tlb_ctrl.sv
// Joint TLB: entry array, registered search ports, TLBWI/TLBWR write port, CP0 Random and flush walk.
module tlb_ctrl
   import tlb_ctrl_pkg::*;
#(
   parameter  int TLBNUM = 32,
   parameter  int NSPORT = 2,
   localparam int IDXW   = $clog2(TLBNUM)
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [NSPORT-1:0]        s_req,
   input  logic [NSPORT*VPN2_W-1:0] s_vpn2,
   input  logic [NSPORT-1:0]        s_odd_page,
   input  logic [NSPORT*ASID_W-1:0] s_asid,
   output logic [NSPORT-1:0]        s_valid,
   output logic [NSPORT-1:0]        s_found,
   output logic [NSPORT-1:0]        s_multi,
   output logic [NSPORT*IDXW-1:0]   s_index,
   output logic [NSPORT*PFN_W-1:0]  s_pfn,
   output logic [NSPORT*C_W-1:0]    s_c,
   output logic [NSPORT-1:0]        s_d,
   output logic [NSPORT-1:0]        s_v,
   input  logic                     we,
   input  logic                     w_random,
   input  logic [IDXW-1:0]          w_index,
   input  logic [TLB_ENTRY_W-1:0]   w_entry,
   input  logic [IDXW-1:0]          r_index,
   output logic [TLB_ENTRY_W-1:0]   r_entry,
   input  logic [IDXW-1:0]          wired,
   output logic [IDXW-1:0]          random_index,
   input  logic                     flush_req,
   input  logic                     flush_by_asid,
   input  logic [ASID_W-1:0]        flush_asid,
   output logic                     flush_busy,
   output logic                     flush_done
);

   localparam logic [IDXW-1:0] LAST = IDXW'(TLBNUM - 1);

   tlb_entry_t                    ent_q [TLBNUM];
   logic [TLBNUM-1:0]             e_q;
   logic [TLBNUM-1:0][VPN2_W-1:0] vpn2_v;
   logic [TLBNUM-1:0][ASID_W-1:0] asid_v;
   logic [TLBNUM-1:0]             g_v;
   logic [NSPORT-1:0]             m_found, m_multi;
   logic [NSPORT-1:0][IDXW-1:0]   m_index;
   logic [NSPORT-1:0][PFN_W-1:0]  pg_pfn;
   logic [NSPORT-1:0][C_W-1:0]    pg_c;
   logic [NSPORT-1:0]             pg_d, pg_v;
   logic [IDXW-1:0]               random_q, random_d, w_target, ptr_q;
   flush_state_e                  state_q, state_d;
   logic                          by_asid_q, flush_clr;
   logic [ASID_W-1:0]             fasid_q;

   always_comb begin
      for (int i = 0; i < TLBNUM; i++) begin
         vpn2_v[i] = ent_q[i].vpn2;
         asid_v[i] = ent_q[i].asid;
         g_v[i]    = ent_q[i].g;
      end
   end

   for (genvar p = 0; p < NSPORT; p++) begin : g_port
      tlb_ctrl_match #(.TLBNUM(TLBNUM)) u_match (
         .e      (e_q),
         .vpn2   (vpn2_v),
         .asid   (asid_v),
         .g      (g_v),
         .q_vpn2 (s_vpn2[p*VPN2_W +: VPN2_W]),
         .q_asid (s_asid[p*ASID_W +: ASID_W]),
         .found  (m_found[p]),
         .multi  (m_multi[p]),
         .index  (m_index[p])
      );
   end

   always_comb begin
      pg_pfn = '0;
      pg_c   = '0;
      pg_d   = '0;
      pg_v   = '0;
      for (int p = 0; p < NSPORT; p++) begin
         if (m_found[p]) begin
            pg_pfn[p] = s_odd_page[p] ? ent_q[m_index[p]].pfn1 : ent_q[m_index[p]].pfn0;
            pg_c[p]   = s_odd_page[p] ? ent_q[m_index[p]].c1   : ent_q[m_index[p]].c0;
            pg_d[p]   = s_odd_page[p] ? ent_q[m_index[p]].d1   : ent_q[m_index[p]].d0;
            pg_v[p]   = s_odd_page[p] ? ent_q[m_index[p]].v1   : ent_q[m_index[p]].v0;
         end
      end
   end

   // NOTE: sequential state uses <= so every register samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         s_valid <= '0;
         s_found <= '0;
         s_multi <= '0;
         s_index <= '0;
         s_pfn   <= '0;
         s_c     <= '0;
         s_d     <= '0;
         s_v     <= '0;
      end else begin
         s_valid <= s_req;
         for (int p = 0; p < NSPORT; p++) begin
            if (s_req[p]) begin
               s_found[p]                 <= m_found[p];
               s_multi[p]                 <= m_multi[p];
               s_index[p*IDXW +: IDXW]    <= m_index[p];
               s_pfn[p*PFN_W +: PFN_W]    <= pg_pfn[p];
               s_c[p*C_W +: C_W]          <= pg_c[p];
               s_d[p]                     <= pg_d[p];
               s_v[p]                     <= pg_v[p];
            end
         end
      end
   end

   assign w_target = w_random ? random_q : w_index;
   assign r_entry  = ent_q[r_index];

   // The write comes after the flush clear, so a write to the walk pointer on the same edge wins.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         // NOTE: only the valid bits are reset; the remaining entry fields keep their contents.
         for (int i = 0; i < TLBNUM; i++) begin
            e_q[i]      <= 1'b0;
            ent_q[i].v0 <= 1'b0;
            ent_q[i].v1 <= 1'b0;
         end
      end else begin
         if (flush_clr) e_q[ptr_q] <= 1'b0;
         if (we) begin
            ent_q[w_target] <= tlb_entry_t'(w_entry);
            e_q[w_target]   <= 1'b1;
         end
      end
   end

   always_comb begin
      if ((wired >= LAST) || (random_q <= wired)) random_d = LAST;
      else                                        random_d = random_q - IDXW'(1);
   end

   always_ff @(posedge clk) begin
      if (!resetn) random_q <= LAST;
      else         random_q <= random_d;
   end

   assign random_index = random_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= FL_IDLE;
         ptr_q     <= '0;
         by_asid_q <= 1'b0;
         fasid_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == FL_IDLE && flush_req) begin
            ptr_q     <= '0;
            by_asid_q <= flush_by_asid;
            fasid_q   <= flush_asid;
         end else if (state_q == FL_WALK) begin
            ptr_q <= ptr_q + IDXW'(1);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FL_IDLE: if (flush_req) state_d = FL_WALK;
         FL_WALK: if (ptr_q == LAST) state_d = FL_DONE;
         FL_DONE: state_d = FL_IDLE;
         default: state_d = FL_IDLE;
      endcase
   end

   always_comb begin
      flush_busy = (state_q == FL_WALK);
      flush_done = (state_q == FL_DONE);
      flush_clr  = (state_q == FL_WALK) && !ent_q[ptr_q].g &&
                   (!by_asid_q || (ent_q[ptr_q].asid == fasid_q));
   end

endmodule

// File: tb/tb_tlb_ctrl.sv
// Randomised and directed bench for tlb_ctrl against an entry-array reference model.
module tb_tlb_ctrl;
   import tlb_ctrl_pkg::*;

   localparam int TLBNUM = 32;
   localparam int NSPORT = 2;
   localparam int IDXW   = 5;

   logic                     clk = 1'b0;
   logic                     resetn = 1'b0;
   logic [NSPORT-1:0]        s_req = '0;
   logic [NSPORT*VPN2_W-1:0] s_vpn2 = '0;
   logic [NSPORT-1:0]        s_odd_page = '0;
   logic [NSPORT*ASID_W-1:0] s_asid = '0;
   logic [NSPORT-1:0]        s_valid, s_found, s_multi, s_d, s_v;
   logic [NSPORT*IDXW-1:0]   s_index;
   logic [NSPORT*PFN_W-1:0]  s_pfn;
   logic [NSPORT*C_W-1:0]    s_c;
   logic                     we = 1'b0, w_random = 1'b0;
   logic [IDXW-1:0]          w_index = '0, r_index = '0, wired = '0, random_index;
   logic [TLB_ENTRY_W-1:0]   w_entry = '0, r_entry;
   logic                     flush_req = 1'b0, flush_by_asid = 1'b0, flush_busy, flush_done;
   logic [ASID_W-1:0]        flush_asid = '0;

   tlb_ctrl #(.TLBNUM(TLBNUM), .NSPORT(NSPORT)) dut (
      .clk(clk), .resetn(resetn), .s_req(s_req), .s_vpn2(s_vpn2), .s_odd_page(s_odd_page),
      .s_asid(s_asid), .s_valid(s_valid), .s_found(s_found), .s_multi(s_multi), .s_index(s_index),
      .s_pfn(s_pfn), .s_c(s_c), .s_d(s_d), .s_v(s_v), .we(we), .w_random(w_random),
      .w_index(w_index), .w_entry(w_entry), .r_index(r_index), .r_entry(r_entry), .wired(wired),
      .random_index(random_index), .flush_req(flush_req), .flush_by_asid(flush_by_asid),
      .flush_asid(flush_asid), .flush_busy(flush_busy), .flush_done(flush_done)
   );

   always #5 clk = ~clk;

   // Reference model: the entry array plus time-since-acceptance for the flush walk.
   logic        m_e  [TLBNUM];
   tlb_entry_t  m_ent[TLBNUM];
   bit          m_wr [TLBNUM];
   int          mrand, fcnt;
   logic        fby;
   logic [7:0]  fasid;
   logic        x_valid[NSPORT], x_found[NSPORT], x_multi[NSPORT], x_d[NSPORT], x_v[NSPORT];
   logic [4:0]  x_index[NSPORT];
   logic [19:0] x_pfn[NSPORT];
   logic [2:0]  x_c[NSPORT];
   logic [18:0] pool[$];
   int          checks = 0, errors = 0;

   task automatic check(input string tag, input logic [77:0] obs, input logic [77:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic tlb_entry_t mk(input logic [18:0] vpn2, input logic [7:0] asid, input logic g);
      tlb_entry_t t;
      logic [31:0] r0, r1;
      r0 = $urandom;
      r1 = $urandom;
      t.vpn2 = vpn2; t.asid = asid; t.g = g;
      t.pfn0 = r0[19:0]; t.c0 = r0[22:20]; t.d0 = r0[23]; t.v0 = r0[24];
      t.pfn1 = r1[19:0]; t.c1 = r1[22:20]; t.d1 = r1[23]; t.v1 = r1[24];
      return t;
   endfunction

   task automatic lookup(input int p);
      int n = 0;
      logic [18:0] v = s_vpn2[p*19 +: 19];
      logic [7:0]  a = s_asid[p*8 +: 8];
      x_found[p] = 0; x_multi[p] = 0; x_index[p] = 0; x_pfn[p] = 0; x_c[p] = 0; x_d[p] = 0; x_v[p] = 0;
      for (int i = 0; i < TLBNUM; i++) begin
         if (m_e[i] && m_ent[i].vpn2 == v && (m_ent[i].g || m_ent[i].asid == a)) begin
            if (n == 0) begin
               x_index[p] = 5'(i);
               x_pfn[p] = s_odd_page[p] ? m_ent[i].pfn1 : m_ent[i].pfn0;
               x_c[p]   = s_odd_page[p] ? m_ent[i].c1   : m_ent[i].c0;
               x_d[p]   = s_odd_page[p] ? m_ent[i].d1   : m_ent[i].d0;
               x_v[p]   = s_odd_page[p] ? m_ent[i].v1   : m_ent[i].v0;
            end
            n++;
         end
      end
      x_found[p] = (n > 0);
      x_multi[p] = (n > 1);
   endtask

   // One clock: predict from pre-edge model, advance model at the edge, compare 1 time unit later.
   task automatic step();
      int wt = w_random ? mrand : int'(w_index);
      for (int p = 0; p < NSPORT; p++) begin
         if (resetn && s_req[p]) lookup(p);
         x_valid[p] = s_req[p];
      end
      @(posedge clk);
      if (!resetn) begin
         for (int i = 0; i < TLBNUM; i++) begin
            m_e[i] = 0; m_ent[i].v0 = 0; m_ent[i].v1 = 0; m_wr[i] = 0;
         end
         for (int p = 0; p < NSPORT; p++) begin
            x_valid[p] = 0; x_found[p] = 0; x_multi[p] = 0; x_index[p] = 0;
            x_pfn[p] = 0; x_c[p] = 0; x_d[p] = 0; x_v[p] = 0;
         end
         mrand = TLBNUM - 1;
         fcnt  = 0;
      end else begin
         if (fcnt >= 1 && fcnt <= TLBNUM) begin
            int k = fcnt - 1;
            if (!m_ent[k].g && (!fby || m_ent[k].asid == fasid)) m_e[k] = 0;
            fcnt++;
         end else if (fcnt == TLBNUM + 1) begin
            fcnt = 0;
         end else if (flush_req) begin
            fcnt = 1; fby = flush_by_asid; fasid = flush_asid;
         end
         if (we) begin
            m_ent[wt] = tlb_entry_t'(w_entry); m_e[wt] = 1; m_wr[wt] = 1;
         end
         if (int'(wired) >= TLBNUM - 1 || mrand <= int'(wired)) mrand = TLBNUM - 1;
         else mrand--;
      end
      #1;
      for (int p = 0; p < NSPORT; p++) begin
         check($sformatf("p%0d_valid", p), 78'(s_valid[p]), 78'(x_valid[p]));
         check($sformatf("p%0d_found", p), 78'(s_found[p]), 78'(x_found[p]));
         check($sformatf("p%0d_multi", p), 78'(s_multi[p]), 78'(x_multi[p]));
         check($sformatf("p%0d_index", p), 78'(s_index[p*5 +: 5]), 78'(x_index[p]));
         check($sformatf("p%0d_pfn", p), 78'(s_pfn[p*20 +: 20]), 78'(x_pfn[p]));
         check($sformatf("p%0d_cdv", p), 78'({s_c[p*3 +: 3], s_d[p], s_v[p]}),
               78'({x_c[p], x_d[p], x_v[p]}));
      end
      check("random_index", 78'(random_index), 78'(mrand));
      check("flush_busy", 78'(flush_busy), 78'(fcnt >= 1 && fcnt <= TLBNUM));
      check("flush_done", 78'(flush_done), 78'(fcnt == TLBNUM + 1));
      if (m_wr[r_index]) check("r_entry", r_entry, m_ent[r_index]);
   endtask

   task automatic rand_search();
      for (int p = 0; p < NSPORT; p++) begin
         s_req[p]            = ($urandom_range(0, 3) != 0);
         s_vpn2[p*19 +: 19]  = (pool.size() > 0) ? pool[$urandom_range(0, pool.size() - 1)] : 19'h0;
         s_asid[p*8 +: 8]    = 8'($urandom_range(0, 3));
         s_odd_page[p]       = 1'($urandom_range(0, 1));
      end
      r_index = 5'($urandom_range(0, TLBNUM - 1));
   endtask

   task automatic write_idx(input int idx, input tlb_entry_t t);
      we = 1; w_random = 0; w_index = 5'(idx); w_entry = t;
      pool.push_back(t.vpn2);
      step();
      we = 0;
   endtask

   initial begin
      tlb_entry_t t;
      int busy_cnt, done_cyc, cyc;
      bit hit7;

      // 1: reset, then a miss on every port
      step();
      check("t1_random", 78'(random_index), 78'(TLBNUM - 1));
      resetn = 1; s_req = '1; s_vpn2 = '0; s_asid = '0;
      step();
      check("t1_valid", 78'(s_valid), 78'(2'b11));
      check("t1_found", 78'(s_found), 78'(0));
      check("t1_index", 78'(s_index), 78'(0));

      // 2: TLBWI and ASID-qualified lookup
      s_req = '0;
      t = '0; t.vpn2 = 19'h12345; t.asid = 8'd3; t.pfn1 = 20'hABCDE; t.v1 = 1'b1;
      write_idx(5, t);
      s_req = 2'b11; s_vpn2 = {19'h12345, 19'h12345}; s_odd_page = 2'b11; s_asid = {8'd4, 8'd3};
      step();
      check("t2_found0", 78'(s_found[0]), 78'(1));
      check("t2_index0", 78'(s_index[4:0]), 78'(5));
      check("t2_pfn0", 78'(s_pfn[19:0]), 78'(20'hABCDE));
      check("t2_v0", 78'(s_v[0]), 78'(1));
      check("t2_found1", 78'(s_found[1]), 78'(0));

      // 3: two global entries with the same VPN2
      write_idx(2, mk(19'h0AAAA, 8'd9, 1'b1));
      write_idx(9, mk(19'h0AAAA, 8'd6, 1'b1));
      s_req = 2'b11; s_vpn2 = {19'h0AAAA, 19'h0AAAA}; s_asid = {8'($urandom), 8'($urandom)};
      step();
      check("t3_found", 78'(s_found), 78'(2'b11));
      check("t3_multi", 78'(s_multi), 78'(2'b11));
      check("t3_index", 78'(s_index), 78'({5'd2, 5'd2}));
      r_index = 5;
      step();
      check("t2_read5", r_entry, 78'(m_ent[5]));

      // 4: Random with wired=4, TLBWR at random=7, then 200 randomised cycles
      wired = 4;
      for (int i = 0; i < 40 && mrand != 4; i++) begin rand_search(); step(); end
      rand_search(); step();
      check("t4_wrap", 78'(random_index), 78'(TLBNUM - 1));
      hit7 = 0;
      for (int i = 0; i < 40 && !hit7; i++) begin
         rand_search();
         if (mrand == 7) begin
            hit7 = 1; we = 1; w_random = 1; w_entry = mk(19'h07777, 8'd1, 1'b0);
            pool.push_back(19'h07777);
         end
         step();
         we = 0; w_random = 0;
      end
      check("t4_hit7", 78'(hit7), 78'(1));
      r_index = 7; s_req = '0;
      step();
      check("t4_entry7", 78'(r_entry[77:59]), 78'(19'h07777));
      for (int i = 0; i < 200; i++) begin
         rand_search();
         we = ($urandom_range(0, 3) == 0); w_random = 1;
         w_entry = mk(19'($urandom), 8'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         step();
         check("t4_above_wired", 78'(random_index >= 5'd4), 78'(1));
      end
      we = 0; w_random = 0;
      for (int i = 0; i < 40 && mrand != 12; i++) step();
      wired = 20;
      step();
      check("t4_below_wired", 78'(random_index), 78'(TLBNUM - 1));
      wired = 31;
      for (int i = 0; i < 4; i++) step();
      check("t4_wired_max", 78'(random_index), 78'(TLBNUM - 1));
      wired = 0;

      // 5: flush by ASID
      for (int i = 10; i <= 15; i++) write_idx(i, mk(19'(32'h100 + i), 8'd1, 1'b0));
      for (int i = 16; i <= 20; i++) write_idx(i, mk(19'(32'h100 + i), 8'd2, 1'b0));
      write_idx(21, mk(19'h115, 8'd1, 1'b1));
      flush_req = 1; flush_by_asid = 1; flush_asid = 8'd1;
      rand_search(); step();
      flush_req = 0;
      busy_cnt = int'(flush_busy); done_cyc = 0; cyc = 1;
      while (done_cyc == 0 && cyc < 40) begin
         rand_search(); step(); cyc++;
         busy_cnt += int'(flush_busy);
         if (flush_done) done_cyc = cyc;
      end
      check("t5_busy_cycles", 78'(busy_cnt), 78'(TLBNUM));
      check("t5_done_cycle", 78'(done_cyc), 78'(TLBNUM + 1));
      s_req = 2'b11; s_odd_page = 0;
      s_vpn2 = {19'h110, 19'h10A}; s_asid = {8'd2, 8'd1};
      step();
      check("t5_asid1_miss", 78'(s_found[0]), 78'(0));
      check("t5_asid2_hit", 78'(s_found[1]), 78'(1));
      s_vpn2 = {19'h110, 19'h115}; s_asid = {8'd2, 8'd1};
      step();
      check("t5_global_hit", 78'(s_found[0]), 78'(1));
      check("t5_global_idx", 78'(s_index[4:0]), 78'(21));

      // 6: write wins over flush clear, then reset aborts the walk
      flush_req = 1; flush_by_asid = 0; s_req = 0;
      step();
      flush_req = 0;
      write_idx(0, mk(19'h02222, 8'd7, 1'b0));
      s_req = 2'b01; s_vpn2 = {19'h0, 19'h02222}; s_asid = {8'd0, 8'd7};
      step();
      check("t6_entry0_kept", 78'(s_found[0]), 78'(1));
      for (int i = 0; i < 5; i++) begin rand_search(); step(); end
      resetn = 0;
      step();
      resetn = 1;
      for (int i = 0; i < 40; i++) begin
         rand_search(); step();
         check("t6_no_hit", 78'(s_found), 78'(0));
      end

      // Full flush of all non-global entries to completion
      for (int i = 0; i < 8; i++) write_idx(i * 4, mk(19'(32'h300 + i), 8'(i), 1'(i % 3 == 0)));
      flush_req = 1; flush_by_asid = 0;
      step();
      flush_req = 0;
      for (int i = 0; i < TLBNUM + 3; i++) begin rand_search(); step(); end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
